handshake_sync_rx: RTL
======================

Name: handshake_sync_rx

Overview:
- Parametrised successor to the single-bit request synchroniser.
- Destination-domain receiver for NUM_CH independent four-phase bundled-data handshakes.
- Per channel:
  - synchronises an asynchronous request through a configurable-depth flop chain;
  - captures a DATA_W-bit payload held stable by the sender;
  - presents the payload to a local consumer with valid/ready;
  - returns a level acknowledge for the four-phase return-to-zero protocol.
- Sits at the destination edge of every multi-bit control crossing.

Parameters:
- NUM_CH, 4, number of independent handshake channels (>=1)
- DATA_W, 8, payload width per channel (>=1)
- SYNC_STAGES, 2, synchroniser depth on req_src (>=2; elaboration error below 2)
- TIMEOUT_CYC, 1024, cycles ACK may wait for request release; used only with HANDSHAKE_TIMEOUT_EN

Ports:
- clk_dst  input  1  destination-domain clock; the only clock
- rst  input  1  synchronous, active-high reset
- req_src  input  NUM_CH  asynchronous request per channel
- data_src  input  NUM_CH*DATA_W  payload; channel c at [c*DATA_W +: DATA_W]; stable while req_src[c] is high
- ack_dst  output  NUM_CH  acknowledge level back to the sender
- out_valid  output  NUM_CH  captured payload available
- out_data  output  NUM_CH*DATA_W  captured payload, same packing as data_src
- out_ready  input  NUM_CH  consumer accepts payload
- busy  output  NUM_CH  channel not in IDLE
- timeout_err  output  NUM_CH  sticky timeout flag; tied 0 without the macro

Behaviour:
- Interface: single clock clk_dst; reset rst is synchronous and active-high.
- Reset values (all channels, regardless of state):
  - sync chain all 0;
  - state IDLE, armed=0;
  - ack_dst=0, out_valid=0, out_data=0, busy=0, timeout_err=0.
- req_sync[c] is the last stage of the chain. data_src is not synchronised; it is sampled only on capture.
- Arming:
  - After reset a channel is disarmed.
  - It becomes armed on the first edge that samples req_sync=0.
  - A request already high across reset is ignored until it falls. This prevents capturing a half-finished transfer.
- States per channel are IDLE, VALID and ACK:
  - IDLE, armed and req_sync=1 → VALID. Same edge: out_data <= data_src slice, out_valid <= 1.
  - VALID, out_valid && out_ready → ACK. Same edge: out_valid <= 0, ack_dst <= 1. out_data is held.
  - VALID without ready → stay. out_valid and out_data held. req_sync falling here is a protocol violation; the transaction still completes.
  - ACK, req_sync=0 → IDLE, ack_dst <= 0.
  - ACK, req_sync=1 → stay, ack_dst=1.
- Latency: req_src rising before edge 1 gives out_valid high after edge SYNC_STAGES+1 (3 by default).
- Ready then drop: if ready is asserted on the first valid cycle and the request drops immediately after ack, the next request can start once the sync chain shows a fresh 0→1 edge.
- busy = (state != IDLE).
- Channels are fully independent: simultaneous events on different channels never interact.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation returns the channel to IDLE and disarms it; ack_dst drops the edge after rst is sampled.

Optional Feature:
- Macro: HANDSHAKE_TIMEOUT_EN.
- With the macro:
  - a per-channel counter, width $clog2(TIMEOUT_CYC+1), clears on ACK entry and increments each ACK cycle with req_sync=1;
  - when it reaches TIMEOUT_CYC, the channel sets timeout_err[c]=1 (sticky until rst), forces IDLE, ack_dst=0 and armed=0.
- Without the macro: no counter, timeout_err tied 0, ACK waits indefinitely.

Decomposition:
- Package handshake_pkg:
  - state typedef hs_state_t {HS_IDLE, HS_VALID, HS_ACK};
  - constant HS_SYNC_STAGES_MIN=2.
- Sub-module handshake_rx_ch: one channel (sync chain, arming, FSM, optional timeout). The top generates NUM_CH instances and packs the slices.

Test Plan:
- Basic transfer, ch0: reset, req_src[0]=1 with data 8'hA5, out_ready=1 → out_valid[0] high after 3 edges with out_data=8'hA5; ack_dst[0]=1 next edge; drop req → ack_dst[0]=0 three edges later.
- Backpressure: out_ready=0 for 10 cycles → out_valid and data held 10 cycles, ack_dst stays 0; ready=1 → ack rises the following edge.
- Reset with req high: req_src[1]=1 during rst → no out_valid while high; drop then raise with 8'h3C → normal capture of 8'h3C.
- Concurrency: all 4 channels request on the same cycle with distinct data 8'h01..8'h04, ready staggered → each channel completes its own data with no cross-talk.
- Mid-operation reset: rst in VALID and again in ACK → outputs zero after the reset edge, busy=0.
- Timeout with HANDSHAKE_TIMEOUT_EN, TIMEOUT_CYC=16: hold req after ack → timeout_err=1 after 16 ACK cycles, ack_dst=0, no recapture until req falls and rises again.

Source files
------------

// File: rtl/handshake_pkg.sv
// handshake_pkg: shared FSM state type and limits for the four-phase receiver
package handshake_pkg;
  typedef enum logic [1:0] {HS_IDLE, HS_VALID, HS_ACK} hs_state_t;
  localparam int HS_SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/handshake_rx_ch.sv
// handshake_rx_ch: one four-phase receive channel (sync chain, arming, FSM, optional ACK timeout)
module handshake_rx_ch
  import handshake_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_dst,
  input  logic              rst,
  input  logic              req_src,
  input  logic [DATA_W-1:0] data_src,
  output logic              ack_dst,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err
);
  if (SYNC_STAGES < HS_SYNC_STAGES_MIN || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("handshake_rx_ch: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
  end
  logic [SYNC_STAGES-1:0] sync, fill;
  logic req_sync, armed, tmo;
  hs_state_t state, state_d;
  assign req_sync = sync[SYNC_STAGES-1];
  // fill marks when req_sync holds a real sample rather than the reset zeros,
  // so a request held high across reset cannot arm the channel
  always_ff @(posedge clk_dst) begin
    if (rst) begin
      sync <= '0;
      fill <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_src};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end
  always_ff @(posedge clk_dst) begin
    if (rst || tmo) armed <= 1'b0;
    else if (fill[SYNC_STAGES-1] && !req_sync) armed <= 1'b1;
  end
  always_ff @(posedge clk_dst) state <= rst ? HS_IDLE : state_d;
  always_comb begin
    state_d = (state == HS_IDLE  && armed && req_sync)   ? HS_VALID :
              (state == HS_VALID && out_ready)           ? HS_ACK   :
              (state == HS_ACK   && (!req_sync || tmo))  ? HS_IDLE  : state;
  end
  always_comb begin
    out_valid = state == HS_VALID;
    ack_dst   = state == HS_ACK;
    busy      = state != HS_IDLE;
  end
  always_ff @(posedge clk_dst) begin
    if (rst) out_data <= '0;
    else if (state == HS_IDLE && state_d == HS_VALID) out_data <= data_src;
  end
`ifdef HANDSHAKE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic err;
  always_ff @(posedge clk_dst) begin
    if (rst || state != HS_ACK) cnt <= '0;
    else if (req_sync) cnt <= cnt + CW'(1);
  end
  assign tmo = state == HS_ACK && req_sync && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_dst) err <= rst ? 1'b0 : (err | tmo);
  assign timeout_err = err;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: rtl/handshake_sync_rx.sv
// handshake_sync_rx: NUM_CH independent four-phase receivers; define HANDSHAKE_TIMEOUT_EN for the ACK timeout
module handshake_sync_rx
  import handshake_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk_dst,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_src,
  input  logic [NUM_CH*DATA_W-1:0] data_src,
  output logic [NUM_CH-1:0]        ack_dst,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        timeout_err
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    handshake_rx_ch #(
      .DATA_W     (DATA_W),
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk_dst    (clk_dst),
      .rst        (rst),
      .req_src    (req_src[c]),
      .data_src   (data_src[c*DATA_W +: DATA_W]),
      .ack_dst    (ack_dst[c]),
      .out_valid  (out_valid[c]),
      .out_data   (out_data[c*DATA_W +: DATA_W]),
      .out_ready  (out_ready[c]),
      .busy       (busy[c]),
      .timeout_err(timeout_err[c])
    );
  end
endmodule
